cmac_ctrl: RTL and testbench

CMAC (RFC 4493 / NIST SP 800-38B) mode controller that sits directly upstream of the AES-128 cipher core and drives it. It derives subkeys K1 and K2 from L = AES(K, 0^128), then takes 128-bit message blocks over a valid/ready handshake. For each block it forms the chained block (previous ciphertext XOR message block, with padding and the K1/K2 XOR on the last block), launches the core, and captures the result. When the last block completes it emits the MAC.

---
 rtl/cmac_ctrl.sv | 144 ++++++++++++++
 tb/tb_cmac_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_ctrl.sv
// CMAC mode controller driving an AES-128 core: subkey derivation, block chaining, padding, MAC output.
// Optional CMAC_VERIFY_EN adds exp_mac input and registered mac_match output.
module cmac_ctrl #(
  parameter int AES_TIMEOUT = 32
) (
  input  logic         CLK,
  input  logic         Rst_n,
  input  logic [127:0] key,
  input  logic         key_ld,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [127:0] msg_data,
  input  logic         msg_last,
  input  logic [4:0]   msg_bytes,
`ifdef CMAC_VERIFY_EN
  input  logic [127:0] exp_mac,
  output logic         mac_match,
`endif
  output logic         mac_valid,
  output logic [127:0] mac,
  output logic         busy,
  output logic         err,
  output logic         aes_ld,
  output logic [127:0] aes_key,
  output logic [127:0] aes_text_in,
  input  logic         aes_done,
  input  logic [127:0] aes_text_out
);

  typedef enum logic [1:0] {IDLE, SUBKEY, READY, BLOCK} state_t;

  localparam logic [7:0] TMO_LAST = 8'(AES_TIMEOUT - 1);

  state_t       state;
  logic [127:0] k1, k2, chain;
  logic [127:0] pad, blk;
  logic         full, last_r;
  logic [7:0]   tmo_cnt;
`ifdef CMAC_VERIFY_EN
  logic [127:0] exp_r;
`endif

  // GF(2^128) doubling used for subkey derivation
  function automatic logic [127:0] dbl(input logic [127:0] v);
    return {v[126:0], 1'b0} ^ {120'd0, (v[127] ? 8'h87 : 8'h00)};
  endfunction

  assign msg_ready = (state == READY) && !key_ld;
  assign busy      = (state == SUBKEY) || (state == BLOCK);

  always_comb begin
    pad = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(msg_bytes))
        pad[127-8*i -: 8] = msg_data[127-8*i -: 8];
      else if (i == int'(msg_bytes))
        pad[127-8*i -: 8] = 8'h80;
    end
    full = !msg_last || (msg_bytes >= 5'd16);
    blk  = chain ^ (full ? msg_data : pad) ^ (!msg_last ? '0 : (full ? k1 : k2));
  end

  always_ff @(posedge CLK) begin
    if (!Rst_n) begin
      state       <= IDLE;
      k1          <= '0;
      k2          <= '0;
      chain       <= '0;
      last_r      <= 1'b0;
      tmo_cnt     <= '0;
      mac_valid   <= 1'b0;
      mac         <= '0;
      err         <= 1'b0;
      aes_ld      <= 1'b0;
      aes_key     <= '0;
      aes_text_in <= '0;
`ifdef CMAC_VERIFY_EN
      exp_r       <= '0;
      mac_match   <= 1'b0;
`endif
    end else begin
      aes_ld    <= 1'b0;
      mac_valid <= 1'b0;
      err       <= 1'b0;
`ifdef CMAC_VERIFY_EN
      mac_match <= 1'b0;
`endif
      if (key_ld) begin
        aes_key     <= key;
        chain       <= '0;
        aes_text_in <= '0;
        aes_ld      <= 1'b1;
        tmo_cnt     <= '0;
        last_r      <= 1'b0;
        state       <= SUBKEY;
      end else begin
        case (state)
          READY: begin
            if (msg_valid) begin
              aes_text_in <= blk;
              aes_ld      <= 1'b1;
              tmo_cnt     <= '0;
              last_r      <= msg_last;
`ifdef CMAC_VERIFY_EN
              exp_r       <= exp_mac;
`endif
              state       <= BLOCK;
            end
          end
          SUBKEY, BLOCK: begin
            // a done coincident with our own launch belongs to an aborted run
            if (aes_done && !aes_ld) begin
              state <= READY;
              if (state == SUBKEY) begin
                k1    <= dbl(aes_text_out);
                k2    <= dbl(dbl(aes_text_out));
                chain <= '0;
              end else if (last_r) begin
                mac       <= aes_text_out;
                mac_valid <= 1'b1;
                chain     <= '0;
`ifdef CMAC_VERIFY_EN
                mac_match <= (aes_text_out == exp_r);
`endif
              end else begin
                chain <= aes_text_out;
              end
            end else if (tmo_cnt == TMO_LAST) begin
              err   <= 1'b1;
              k1    <= '0;
              k2    <= '0;
              chain <= '0;
              state <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmac_ctrl.sv
// Bench for cmac_ctrl: behavioural AES core + CMAC model, per-cycle compare process, RFC 4493 vectors.
module tb_cmac_ctrl;
  localparam int TO = 32;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [511:0] RFC_MSG = 512'h6bc1bee22e409f96e93d7e117393172aae2d8a571e03ac9c9eb76fac45af8e5130c81c46a35ce411e5fbc1191a0a52eff69f2445df4f9b17ad2b417be66c3710;

  logic CLK = 1'b0;
  logic Rst_n;
  logic [127:0] key;
  logic key_ld, msg_valid, msg_ready, msg_last;
  logic [127:0] msg_data;
  logic [4:0] msg_bytes;
  logic mac_valid, busy, err, aes_ld, aes_done;
  logic [127:0] mac, aes_key, aes_text_in, aes_text_out;
`ifdef CMAC_VERIFY_EN
  logic [127:0] exp_mac;
  logic mac_match;
  logic exp_match;
`endif

  always #5 CLK = ~CLK;

  cmac_ctrl #(.AES_TIMEOUT(TO)) dut (
    .CLK(CLK), .Rst_n(Rst_n), .key(key), .key_ld(key_ld),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_last(msg_last), .msg_bytes(msg_bytes),
`ifdef CMAC_VERIFY_EN
    .exp_mac(exp_mac), .mac_match(mac_match),
`endif
    .mac_valid(mac_valid), .mac(mac), .busy(busy), .err(err),
    .aes_ld(aes_ld), .aes_key(aes_key), .aes_text_in(aes_text_in),
    .aes_done(aes_done), .aes_text_out(aes_text_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired waiting for DUT", name);
  endtask

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] a, inv;
    for (int v = 0; v < 256; v++) begin
      a = 8'(v);
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, a);
      sbox_t[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] s, n, m;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'd0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) n[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          m[127-8*(rr+4*c) -: 8] = n[127-8*(rr+4*((c+rr)%4)) -: 8];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = m[127-32*c -: 8];  a1 = m[119-32*c -: 8];
          a2 = m[111-32*c -: 8];  a3 = m[103-32*c -: 8];
          m[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          m[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          m[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          m[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = m ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  function automatic logic [127:0] dbl(input logic [127:0] v);
    return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
  endfunction

  // ---------------- CMAC model and expectation queues ----------------
  logic [7:0]   cur_msg [$];
  logic [127:0] blk_q [$];
  logic [127:0] mac_q [$];
  logic [127:0] model_key;

  task automatic model_msg(output logic [127:0] mac_o);
    int n, nbk, idx;
    bit complete;
    logic [127:0] l, k1, k2, x, mb;
    n = cur_msg.size();
    nbk = (n == 0) ? 1 : (n + 15) / 16;
    complete = (n != 0) && (n % 16 == 0);
    l  = aes_enc(model_key, 128'h0);
    k1 = dbl(l);
    k2 = dbl(k1);
    x  = '0;
    for (int b = 0; b < nbk; b++) begin
      for (int j = 0; j < 16; j++) begin
        idx = 16*b + j;
        mb[127-8*j -: 8] = (idx < n) ? cur_msg[idx] : ((idx == n) ? 8'h80 : 8'h00);
      end
      if (b == nbk - 1) mb = mb ^ (complete ? k1 : k2);
      blk_q.push_back(x ^ mb);
      x = aes_enc(model_key, x ^ mb);
    end
    mac_q.push_back(x);
    mac_o = x;
  endtask

  task automatic load_msg(input int n);
    logic [511:0] mm;
    mm = RFC_MSG;
    cur_msg.delete();
    for (int i = 0; i < n; i++) cur_msg.push_back(mm[511-8*i -: 8]);
  endtask

  // ---------------- behavioural AES core ----------------
  int core_lat = 3;
  bit core_hold = 1'b0;
  bit core_pend = 1'b0;
  int core_cnt;
  logic [127:0] core_res, core_in;

  always @(negedge CLK) begin
    aes_done = 1'b0;
    if (aes_ld) begin
      core_pend = 1'b1;
      core_cnt  = core_lat;
      core_res  = aes_enc(aes_key, aes_text_in);
      core_in   = aes_text_in;
    end else if (core_pend && Rst_n) begin
      check("aes_text_in_held", aes_text_in, core_in);
      if (!core_hold) begin
        core_cnt--;
        if (core_cnt == 0) begin
          aes_done     = 1'b1;
          aes_text_out = core_res;
          core_pend    = 1'b0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  bit chk_en = 1'b1;
  bit err_ok = 1'b0;
  int cyc = 0, ld_cyc = 0, err_cyc = 0, mac_cnt = 0, err_cnt = 0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (mac_valid) mac_cnt++;
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (chk_en && Rst_n) begin
      if (aes_ld) begin
        ld_cyc = cyc;
        check("aes_key", aes_key, model_key);
        if (blk_q.size() == 0) check("unexpected_aes_ld", 1'b1, 1'b0);
        else check("aes_text_in", aes_text_in, blk_q.pop_front());
      end
      if (mac_valid) begin
        if (mac_q.size() == 0) check("unexpected_mac_valid", 1'b1, 1'b0);
        else check("mac", mac, mac_q.pop_front());
`ifdef CMAC_VERIFY_EN
        check("mac_match", {127'd0, mac_match}, {127'd0, exp_match});
`endif
      end
      if (err) check("err_allowed", {127'd0, err_ok}, 128'd1);
      if (mac_valid && err) check("mac_valid_and_err", 1'b1, 1'b0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(input string name);
    int w;
    w = 0;
    while (w < 200) begin
      @(negedge CLK); #1;
      if (msg_ready) break;
      w++;
    end
    if (w >= 200) timeout_fail(name);
    else check(name, {127'd0, msg_ready}, 128'd1);
  endtask

  task automatic do_key(input logic [127:0] k);
    model_key = k;
    blk_q.push_back(128'h0);
    @(negedge CLK);
    key = k;
    key_ld = 1'b1;
    @(negedge CLK);
    key_ld = 1'b0;
    wait_ready("msg_ready_after_subkey");
  endtask

  task automatic send_block(input int b, input bit over);
    int n, nbk, rem, idx, w;
    n = cur_msg.size();
    nbk = (n == 0) ? 1 : (n + 15) / 16;
    rem = n - 16*b;
    @(negedge CLK);
    for (int j = 0; j < 16; j++) begin
      idx = 16*b + j;
      msg_data[127-8*j -: 8] = (idx < n) ? cur_msg[idx] : 8'hA5;
    end
    msg_last = (b == nbk - 1);
    if (msg_last) msg_bytes = (rem >= 16) ? (over ? 5'd20 : 5'd16) : 5'(rem);
    else msg_bytes = (b % 2 == 1) ? 5'd0 : 5'd9;
    msg_valid = 1'b1;
    #1;
    w = 0;
    while (!msg_ready && w < 200) begin
      @(negedge CLK); #1;
      w++;
    end
    if (w >= 200) timeout_fail("block_accept");
    @(posedge CLK); #1;
    msg_valid = 1'b0;
    msg_last = 1'b0;
  endtask

  task automatic run_msg(input int n, input bit stall, input bit over,
                         input logic [127:0] lit, input string name);
    logic [127:0] m;
    int prev, w, nbk;
    load_msg(n);
    model_msg(m);
    check({name, "_model"}, m, lit);
    prev = mac_cnt;
    nbk = (n == 0) ? 1 : (n + 15) / 16;
    for (int b = 0; b < nbk; b++) begin
      if (stall) repeat (3) @(negedge CLK);
      send_block(b, over);
    end
    w = 0;
    while (mac_cnt == prev && w < 200) begin
      @(posedge CLK); #1;
      w++;
    end
    if (w >= 200) timeout_fail({name, "_mac_valid"});
    repeat (2) @(posedge CLK); #1;
    check({name, "_dut_mac"}, mac, lit);
    check({name, "_one_pulse"}, 128'(mac_cnt - prev), 128'd1);
    check({name, "_queues_drained"}, 128'(blk_q.size() + mac_q.size()), 128'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int prev, w;
    logic [127:0] kk1;
    Rst_n = 1'b0; key = '0; key_ld = 1'b0; msg_valid = 1'b0; msg_data = '0;
    msg_last = 1'b0; msg_bytes = '0; aes_done = 1'b0; aes_text_out = '0;
    model_key = '0;
`ifdef CMAC_VERIFY_EN
    exp_mac = '0; exp_match = 1'b0;
`endif
    build_sbox();
    repeat (3) @(posedge CLK); #1;
    check("rst_mac", mac, 128'h0);
    check("rst_flags", {122'd0, mac_valid, busy, err, aes_ld, msg_ready, 1'b0}, 128'h0);
    check("rst_aes_key", aes_key, 128'h0);
    check("rst_aes_text_in", aes_text_in, 128'h0);
    @(negedge CLK);
    Rst_n = 1'b1;

    // pin the reference model to RFC 4493 subkey values
    check("model_L", aes_enc(KEY, 128'h0), 128'h7df76b0c1ab899b33e42f047b91b546f);
    kk1 = dbl(aes_enc(KEY, 128'h0));
    check("model_K1", kk1, 128'hfbeed618357133667c85e08f7236a8de);
    check("model_K2", dbl(kk1), 128'hf7ddac306ae266ccf90bc11ee46d513b);

    do_key(KEY);

    load_msg(0);
    begin
      logic [127:0] m;
      model_msg(m);
      check("empty_block_model", blk_q[0], 128'h77ddac306ae266ccf90bc11ee46d513b);
      blk_q.delete();
      mac_q.delete();
    end
    run_msg(0,  1'b0, 1'b0, 128'hbb1d6929e95937287fa37d129b756746, "empty");
    run_msg(16, 1'b0, 1'b1, 128'h070a16b46b4d4144f79bdd9dd04a287c, "one_block");
    run_msg(40, 1'b0, 1'b0, 128'hdfa66747de9ae63030ca32611497c827, "msg40");
    core_lat = 6;
    run_msg(40, 1'b1, 1'b0, 128'hdfa66747de9ae63030ca32611497c827, "msg40_stall");
    core_lat = 3;
    run_msg(64, 1'b0, 1'b0, 128'h51f0bebf7e3b9d92fc49741779363cfe, "msg64");

    // abort during block 2
    begin
      logic [127:0] m;
      load_msg(64);
      model_msg(m);
      prev = mac_cnt;
      send_block(0, 1'b0);
      send_block(1, 1'b0);
      @(negedge CLK); #2;
      key = KEY;
      key_ld = 1'b1;
      blk_q.delete();
      mac_q.delete();
      blk_q.push_back(128'h0);
      @(negedge CLK);
      key_ld = 1'b0;
      wait_ready("msg_ready_after_abort");
      repeat (10) @(negedge CLK);
      check("abort_no_mac_valid", 128'(mac_cnt - prev), 128'd0);
    end
    run_msg(64, 1'b0, 1'b0, 128'h51f0bebf7e3b9d92fc49741779363cfe, "after_abort");

    // AES timeout
    begin
      logic [127:0] m;
      core_hold = 1'b1;
      err_ok = 1'b1;
      load_msg(16);
      model_msg(m);
      prev = err_cnt;
      send_block(0, 1'b0);
      w = 0;
      while (err_cnt == prev && w < 200) begin
        @(posedge CLK); #1;
        w++;
      end
      if (w >= 200) timeout_fail("err_pulse");
      check("err_latency", 128'(err_cyc - ld_cyc), 128'(TO));
      @(negedge CLK); #1;
      check("timeout_idle", {126'd0, msg_ready, busy}, 128'h0);
      repeat (40) @(negedge CLK);
      check("err_single_pulse", 128'(err_cnt - prev), 128'd1);
      mac_q.delete();
      blk_q.delete();
      core_hold = 1'b0;
      err_ok = 1'b0;
    end

    do_key(KEY);
`ifdef CMAC_VERIFY_EN
    exp_mac = 128'h070a16b46b4d4144f79bdd9dd04a287c;
    exp_match = 1'b1;
    run_msg(16, 1'b0, 1'b0, 128'h070a16b46b4d4144f79bdd9dd04a287c, "verify_ok");
    exp_mac = 128'h070a16b46b4d4144f79bdd9dd04a287d;
    exp_match = 1'b0;
    run_msg(16, 1'b0, 1'b0, 128'h070a16b46b4d4144f79bdd9dd04a287c, "verify_bad");
`else
    run_msg(16, 1'b0, 1'b0, 128'h070a16b46b4d4144f79bdd9dd04a287c, "after_timeout");
`endif

    // reset mid-operation
    chk_en = 1'b0;
    @(negedge CLK);
    key_ld = 1'b1;
    @(negedge CLK);
    key_ld = 1'b0;
    #1;
    check("busy_in_subkey", {127'd0, busy}, 128'd1);
    @(negedge CLK);
    Rst_n = 1'b0;
    @(posedge CLK); #1;
    check("midrst_mac_cleared", mac, 128'h0);
    check("midrst_flags", {124'd0, busy, msg_ready, aes_ld, mac_valid}, 128'h0);
    check("midrst_aes_key", aes_key, 128'h0);
    @(negedge CLK);
    Rst_n = 1'b1;
    repeat (5) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
